ecc_scalar_sched: RTL
=====================

# ecc_scalar_sched

Scalar-multiplication sequencer for the ECC core. It takes a 32-bit scalar k and walks it MSB-first with left-to-right double-and-add. For each step it issues LOAD / PDBL / PADD commands to the point-arithmetic unit over a valid/ready command channel, and waits for the unit's done pulse before issuing the next command. It sits between the operand loader (which assembles k) and the point unit, and is the only source of point-unit commands.

## Interface
- KW, 32, scalar width in bits (≥2).
- IW, 5, bit-index width, equal to clog2(KW).

- i_clk, in, 1: clock, rising edge.
- i_rst_n, in, 1: asynchronous active-low reset.
- i_start, in, 1: start request; accepted only in IDLE.
- i_k, in, KW: scalar; sampled on an accepted start.
- o_busy, out, 1: high from the cycle after acceptance through the FINISH cycle.
- o_op_valid, out, 1: command valid.
- o_op, out, 2: command. 00 NOP, 01 PDBL (Q=2Q), 10 PADD (Q=Q+P), 11 LOAD (Q=P).
- i_op_ready, in, 1: point unit accepts the command when o_op_valid & i_op_ready.
- i_op_done, in, 1: one-cycle completion pulse from the point unit.
- o_done, out, 1: one-cycle pulse; Q holds k·P.
- o_inf, out, 1: result is the point at infinity (k==0); valid with o_done, held until next accepted start.
- o_bit_idx, out, IW: index of the bit currently being processed (debug).

## Operation
- Registers:
  - kreg (KW): scalar being shifted, MSB-aligned.
  - cnt (IW): bits remaining below the current bit.
  - cur_op (2): last command issued.
- IDLE: on i_start, load kreg=i_k and cnt=KW-1, clear o_inf, then go to SCAN.
- SCAN, one bit per cycle:
  - kreg==0: set o_inf=1 and go to FINISH.
  - kreg[KW-1]==0: shift kreg left by 1, decrement cnt, stay in SCAN.
  - kreg[KW-1]==1: set cur_op=LOAD and go to ISSUE.
- ISSUE: o_op_valid=1, o_op=cur_op. On a handshake, go to WAIT.
- WAIT: on i_op_done, choose the next step:
  - cur_op is LOAD or PADD: if cnt==0, go to FINISH. Otherwise shift kreg, decrement cnt, set cur_op=PDBL, go to ISSUE.
  - cur_op is PDBL: if kreg[KW-1]==1, set cur_op=PADD and go to ISSUE. Else if cnt==0, go to FINISH. Else shift kreg, decrement cnt, set cur_op=PDBL, go to ISSUE.
- FINISH: o_done=1 for one cycle, then go to IDLE.
- Command count for bit length L and popcount w: 1 LOAD, L-1 PDBL, w-1 PADD.
- o_bit_idx equals cnt.

## Timing
- Reset values: state=IDLE, kreg=0, cnt=0, cur_op=NOP. All outputs 0, o_op=00.
- Start accepted in cycle t: SCAN begins at t+1.
  - k with MSB at bit 31: first ISSUE at t+2.
  - k==0: o_done and o_inf at t+2.
  - General case: SCAN lasts (KW − L + 1) cycles.
- o_op_valid and o_op are registered. Both stay stable while valid and not ready. Valid drops the cycle after the handshake.
- Minimum gap between i_op_done and the next o_op_valid is one cycle.
- Command-channel outputs are zero outside ISSUE.
- Boundary conditions:
  - i_start while busy: ignored.
  - i_start in the FINISH cycle: ignored; it is accepted only in IDLE.
  - i_op_done outside WAIT, including in the same cycle as the handshake: ignored. The point unit asserts done at least one cycle after acceptance.
  - Reset mid-operation: immediate return to reset values. Any in-flight command is abandoned, and the point unit shares i_rst_n.
  - cnt never wraps, because the shift/decrement only occurs when cnt>0.

## Structure
- Shared package ecc_pkg holds:
  - Op encodings: OP_NOP, OP_PDBL, OP_PADD, OP_LOAD.
  - State enum: IDLE, SCAN, ISSUE, WAIT, FINISH.
  - Default KW.
- One natural sub-module, ecc_key_shifter, holds kreg and cnt. Its controls are load, shift/decrement and clear. Its outputs are msb, zero and cnt_zero.
- The FSM and command channel stay in ecc_scalar_sched.

## Test plan
- k=0x00000000, ready tied high: o_done and o_inf at t+2; zero commands issued.
- k=0x00000001: 31 SCAN shifts, then LOAD only. o_done one cycle after its i_op_done, with o_inf=0.
- k=0x0000000B: command sequence is exactly LOAD, PDBL, PDBL, PADD, PDBL, PADD. o_bit_idx steps 3→2→1→0.
- k=0x80000000: first ISSUE at t+2. Sequence is LOAD plus 31 PDBL, with no PADD.
- k=0x5, i_op_ready low for 3 cycles during PDBL: o_op_valid held and o_op=01 stable. Spurious i_op_done pulses in ISSUE are ignored.
- Mid-run behaviour:
  - i_start pulsed during the run is ignored; the sequence is unchanged.
  - i_rst_n asserted during WAIT forces all outputs to 0 and returns to IDLE.
  - A new start after reset runs cleanly.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC scalar-multiplication sequencer: command
// encodings, sequencer states and the default scalar width.
package ecc_pkg;

    localparam int unsigned KW_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_PDBL = 2'b01,
        OP_PADD = 2'b10,
        OP_LOAD = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        ISSUE,
        WAIT,
        FINISH
    } state_e;

endpackage

// File: rtl/ecc_key_shifter.sv
// Holds the MSB-aligned scalar and the count of bits remaining below the
// current bit; the sequencer loads, shifts or clears it.
module ecc_key_shifter #(
    parameter int unsigned KW = 32,
    parameter int unsigned IW = 5
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_load,
    input  logic          i_shift,
    input  logic          i_clear,
    input  logic [KW-1:0] i_k,
    output logic          o_msb,
    output logic          o_zero,
    output logic          o_cnt_zero,
    output logic [IW-1:0] o_cnt
);

    logic [KW-1:0] kreg_q;
    logic [IW-1:0] cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            kreg_q <= '0;
            cnt_q  <= '0;
        end else if (i_clear) begin
            kreg_q <= '0;
            cnt_q  <= '0;
        end else if (i_load) begin
            kreg_q <= i_k;
            cnt_q  <= IW'(KW - 1);
        end else if (i_shift) begin
            kreg_q <= {kreg_q[KW-2:0], 1'b0};
            cnt_q  <= cnt_q - IW'(1);
        end
    end

    assign o_msb      = kreg_q[KW-1];
    assign o_zero     = (kreg_q == '0);
    assign o_cnt_zero = (cnt_q == '0);
    assign o_cnt      = cnt_q;

endmodule

// File: rtl/ecc_scalar_sched.sv
// Left-to-right double-and-add sequencer: walks k MSB-first and issues
// LOAD/PDBL/PADD commands to the point unit, one outstanding at a time.
module ecc_scalar_sched
    import ecc_pkg::*;
#(
    parameter int unsigned KW = KW_DEFAULT,
    parameter int unsigned IW = $clog2(KW)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic [KW-1:0] i_k,
    output logic          o_busy,
    output logic          o_op_valid,
    output logic [1:0]    o_op,
    input  logic          i_op_ready,
    input  logic          i_op_done,
    output logic          o_done,
    output logic          o_inf,
    output logic [IW-1:0] o_bit_idx
);

    state_e state_q, state_d;
    op_e    cur_op_q, cur_op_d;
    logic   inf_q, inf_d;

    logic ks_load, ks_shift, ks_clear;
    logic ks_msb, ks_zero, ks_cnt_zero;

    ecc_key_shifter #(
        .KW (KW),
        .IW (IW)
    ) u_key_shifter (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (ks_load),
        .i_shift    (ks_shift),
        .i_clear    (ks_clear),
        .i_k        (i_k),
        .o_msb      (ks_msb),
        .o_zero     (ks_zero),
        .o_cnt_zero (ks_cnt_zero),
        .o_cnt      (o_bit_idx)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            cur_op_q <= OP_NOP;
            inf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_op_q <= cur_op_d;
            inf_q    <= inf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cur_op_d = cur_op_q;
        inf_d    = inf_q;
        ks_load  = 1'b0;
        ks_shift = 1'b0;
        ks_clear = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    ks_load = 1'b1;
                    inf_d   = 1'b0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (ks_zero) begin
                    inf_d   = 1'b1;
                    state_d = FINISH;
                end else if (ks_msb) begin
                    cur_op_d = OP_LOAD;
                    state_d  = ISSUE;
                end else begin
                    // A nonzero kreg with a clear MSB always has bits left below
                    ks_shift = !ks_cnt_zero;
                end
            end
            ISSUE: begin
                if (i_op_ready) state_d = WAIT;
            end
            WAIT: begin
                if (i_op_done) begin
                    // After a doubling the MSB is the current bit: add if it is set
                    if (cur_op_q == OP_PDBL && ks_msb) begin
                        cur_op_d = OP_PADD;
                        state_d  = ISSUE;
                    end else if (ks_cnt_zero) begin
                        state_d = FINISH;
                    end else begin
                        ks_shift = 1'b1;
                        cur_op_d = OP_PDBL;
                        state_d  = ISSUE;
                    end
                end
            end
            FINISH: begin
                ks_clear = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_busy     = (state_q != IDLE);
    assign o_op_valid = (state_q == ISSUE);
    assign o_op       = (state_q == ISSUE) ? cur_op_q : OP_NOP;
    assign o_done     = (state_q == FINISH);
    assign o_inf      = inf_q;

endmodule
